ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive MEM grants allowed while IF waits.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port if_req  input  1  IF fetch request (32-bit read), held until if_done or if_flush.
REQ-005 SHALL have port if_addr  input  32  IF fetch byte address.
REQ-006 SHALL have port if_flush  input  1  cancel pending/active IF fetch (jump/mispredict).
REQ-007 SHALL have port if_done  output  1  one-cycle pulse, if_rdata valid.
REQ-008 SHALL have port if_rdata  output  32  fetched word, little-endian.
REQ-009 SHALL have port mem_req  input  1  load/store request, held until mem_done.
REQ-010 SHALL have port mem_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port mem_wide  input  2  0 = byte, 1 = half, 2 = word, 3 = word.
REQ-012 SHALL have port mem_signed  input  1  sign-extend load result.
REQ-013 SHALL have port mem_addr  input  32  byte address; any alignment.
REQ-014 SHALL have port mem_wdata  input  32  store data, byte 0 written first.
REQ-015 SHALL have port mem_done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port mem_rdata  output  32  load result, valid with mem_done.
REQ-017 SHALL have port ram_rw  output  1  1 = write.
REQ-018 SHALL have port ram_addr  output  32  byte address.
REQ-019 SHALL have port ram_wdata  output  8  write byte.
REQ-020 SHALL have port ram_rdata  input  8  read byte, valid one cycle after its address.
REQ-021 SHALL have port busy  output  1  high while not IDLE.

Function
REQ-022 SHALL have states IDLE, RD, WR; RAM outputs registered.
REQ-023 In IDLE, ram_rw = 0, ram_addr = 0, ram_wdata = 0.
REQ-024 In IDLE with one request, that request is granted at the next edge; address, data, width and sign are latched at grant; later input changes are ignored.
REQ-025 Simultaneous requests: MEM wins; IF wins only when the starvation guard fires (REQ-036).
REQ-026 Byte count N = 1/2/4 from width; IF N = 4; byte k goes to latched address + k, k = 0..N-1, one byte per cycle starting the cycle after grant.
REQ-027 RD: byte k is captured from ram_rdata one cycle after address k; the done pulse and result are registered on the edge N+1 after grant; FSM returns to IDLE on that edge.
REQ-028 WR: ram_rw = 1 with ram_wdata = mem_wdata byte k for cycles 1..N; mem_done pulses on edge N; FSM returns to IDLE on that edge.
REQ-029 Load result: zero-extended if mem_signed = 0, else sign-extended from bit 8N-1; store mem_rdata = 0.
REQ-030 if_rdata and mem_rdata hold their last values between done pulses; only the served client gets a done pulse.
REQ-031 if_flush in IDLE or during an IF read aborts the read: no further addresses issued, no if_done, IDLE on the next edge; an ungranted if_req in that same cycle is ignored.
REQ-032 if_flush during a MEM transaction has no effect.
REQ-033 No grant on a done edge; minimum one IDLE cycle between transactions.

Reset
REQ-034 rst forces IDLE, zeroes all outputs and the starvation counter, and aborts any transaction mid-operation with no done pulse and no further RAM writes.

Configuration
REQ-035 The macro ARB_STARVE_GUARD_EN compiles in the starvation guard.
REQ-036 With the macro: a counter increments on each MEM grant while if_req is high, clears on IF grant, and saturates at STARVE_LIMIT; when it equals STARVE_LIMIT, a contested grant goes to IF. Without the macro: strict MEM priority and no counter.

Verification
REQ-037 Test 1, IF read at 0x100 (RAM bytes 0x13, 0x05, 0x00, 0x00) -> addresses 0x100..0x103 on consecutive cycles; if_done on edge 5 after grant; if_rdata = 0x00000513.
REQ-038 Test 2, MEM signed half load at 0x201 (bytes 0x34, 0x80) -> mem_rdata = 0xFFFF8034; unsigned -> 0x00008034.
REQ-039 Test 3, MEM word store of 0xDEADBEEF at 0x40 -> writes EF, BE, AD, DE to 0x40..0x43 with ram_rw = 1; mem_done on edge 4.
REQ-040 Test 4, simultaneous if_req and mem_req -> MEM served first, then IF after one IDLE cycle; the IF request is held throughout.
REQ-041 Test 5, if_flush asserted two cycles into an IF read -> no if_done, IDLE next edge, ram_addr = 0; rst during a store -> no mem_done and no later writes.
REQ-042 Test 6, with ARB_STARVE_GUARD_EN, STARVE_LIMIT = 4, and continuous mem_req plus if_req -> fifth grant goes to IF; without the macro, IF is never granted.

Source files
------------

// File: rtl/ram_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto a byte-wide RAM.
// Define ARB_STARVE_GUARD_EN to compile in the IF starvation guard (STARVE_LIMIT).
module ram_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_wide,
    input  logic        mem_signed,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic        ram_rw,
    output logic [31:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t      state_reg, state_next;
    logic [2:0]  cnt_reg, cnt_next;
    logic        is_if_reg, is_if_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [1:0]  wide_reg, wide_next;
    logic        sgn_reg, sgn_next;
    logic [31:0] cap_reg, cap_next;
    logic        ram_rw_reg, ram_rw_next;
    logic [31:0] ram_addr_reg, ram_addr_next;
    logic [7:0]  ram_wdata_reg, ram_wdata_next;
    logic        if_done_reg, if_done_next;
    logic [31:0] if_rdata_reg, if_rdata_next;
    logic        mem_done_reg, mem_done_next;
    logic [31:0] mem_rdata_reg, mem_rdata_next;

    logic        idle, if_ok, grant_if, grant_mem, starve_hit;
    logic [2:0]  nbytes, cnt_plus;
    logic [1:0]  last_idx, cap_idx;
    logic [31:0] raw_word, load_word;

    assign idle      = (state_reg == IDLE);
    assign if_ok     = if_req & ~if_flush;
    assign grant_if  = idle & if_ok & (~mem_req | starve_hit);
    assign grant_mem = idle & mem_req & ~grant_if;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_reg;

    always_ff @(posedge clk) begin
        if (rst)
            starve_reg <= '0;
        else if (grant_if)
            starve_reg <= '0;
        else if (grant_mem && if_req && starve_reg != SW'(STARVE_LIMIT))
            starve_reg <= starve_reg + 1'b1;
    end

    assign starve_hit = (starve_reg == SW'(STARVE_LIMIT));
`else
    // Strict MEM priority; the limit only matters when the guard is built in.
    assign starve_hit = (STARVE_LIMIT < 0);
`endif

    always_comb begin
        case (wide_reg)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    assign cnt_plus = cnt_reg + 3'd1;
    assign last_idx = 2'(nbytes - 3'd1);
    assign cap_idx  = cnt_reg[1:0] - 2'd1;

    // The final byte is taken straight off the RAM bus on the done edge.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_raw
            assign raw_word[8*gi +: 8] = (last_idx == 2'(gi)) ? ram_rdata : cap_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        case (wide_reg)
            2'd0:    load_word = {{24{sgn_reg & raw_word[7]}}, raw_word[7:0]};
            2'd1:    load_word = {{16{sgn_reg & raw_word[15]}}, raw_word[15:0]};
            default: load_word = raw_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            is_if_reg     <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wide_reg      <= '0;
            sgn_reg       <= 1'b0;
            cap_reg       <= '0;
            ram_rw_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            if_done_reg   <= 1'b0;
            if_rdata_reg  <= '0;
            mem_done_reg  <= 1'b0;
            mem_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            is_if_reg     <= is_if_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            wide_reg      <= wide_next;
            sgn_reg       <= sgn_next;
            cap_reg       <= cap_next;
            ram_rw_reg    <= ram_rw_next;
            ram_addr_reg  <= ram_addr_next;
            ram_wdata_reg <= ram_wdata_next;
            if_done_reg   <= if_done_next;
            if_rdata_reg  <= if_rdata_next;
            mem_done_reg  <= mem_done_next;
            mem_rdata_reg <= mem_rdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        is_if_next     = is_if_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        wide_next      = wide_reg;
        sgn_next       = sgn_reg;
        cap_next       = cap_reg;
        ram_rw_next    = 1'b0;
        ram_addr_next  = '0;
        ram_wdata_next = '0;
        if_done_next   = 1'b0;
        if_rdata_next  = if_rdata_reg;
        mem_done_next  = 1'b0;
        mem_rdata_next = mem_rdata_reg;

        case (state_reg)
            IDLE: begin
                if (grant_mem) begin
                    state_next     = mem_we ? WR : RD;
                    cnt_next       = '0;
                    is_if_next     = 1'b0;
                    addr_next      = mem_addr;
                    wdata_next     = mem_wdata;
                    wide_next      = mem_wide;
                    sgn_next       = mem_signed;
                    ram_rw_next    = mem_we;
                    ram_addr_next  = mem_addr;
                    ram_wdata_next = mem_we ? mem_wdata[7:0] : 8'h00;
                end else if (grant_if) begin
                    state_next    = RD;
                    cnt_next      = '0;
                    is_if_next    = 1'b1;
                    addr_next     = if_addr;
                    wide_next     = 2'd2;
                    sgn_next      = 1'b0;
                    ram_addr_next = if_addr;
                end
            end
            RD: begin
                if (is_if_reg && if_flush) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_plus;
                    if (cnt_plus < nbytes)
                        ram_addr_next = addr_reg + 32'(cnt_plus);
                    if (cnt_reg != 3'd0 && cnt_reg < nbytes)
                        cap_next[8*cap_idx +: 8] = ram_rdata;
                    if (cnt_reg == nbytes) begin
                        state_next = IDLE;
                        if (is_if_reg) begin
                            if_done_next  = 1'b1;
                            if_rdata_next = load_word;
                        end else begin
                            mem_done_next  = 1'b1;
                            mem_rdata_next = load_word;
                        end
                    end
                end
            end
            WR: begin
                cnt_next = cnt_plus;
                if (cnt_plus < nbytes) begin
                    ram_rw_next    = 1'b1;
                    ram_addr_next  = addr_reg + 32'(cnt_plus);
                    ram_wdata_next = wdata_reg[8*cnt_plus[1:0] +: 8];
                end else begin
                    state_next     = IDLE;
                    mem_done_next  = 1'b1;
                    mem_rdata_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ram_rw    = ram_rw_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_wdata = ram_wdata_reg;
    assign if_done   = if_done_reg;
    assign if_rdata  = if_rdata_reg;
    assign mem_done  = mem_done_reg;
    assign mem_rdata = mem_rdata_reg;
    assign busy      = ~idle;
endmodule
